// File: rtl/arf_sequencer.sv
// Micro-sequencer owning ARF/memory/IR controls for fetch, stack, call/return and load ops.
// Latency: op accepted at the Start edge in IDLE; step outputs follow one cycle later, N = 1..4 steps.
// Backpressure: none queued; Start is ignored while Busy, so the caller must wait for the IDLE cycle after Done.
module arf_sequencer (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [2:0] Op,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] OutCSel,
  output logic [1:0] OutDSel,
  output logic [2:0] FunSel,
  output logic [2:0] RegSel,
  output logic       ArfISel,
  output logic       MemRd,
  output logic       MemWr,
  output logic       DataByte,
  output logic       IRLoad,
  output logic       IRLH,
  output logic       PopLoad
);

  typedef enum logic [4:0] {
    S_IDLE,
    S_F0, S_F1,
    S_P0, S_P1,
    S_Q0, S_Q1, S_Q2,
    S_LPC, S_LSP, S_LAR,
    S_C0, S_C1, S_C2,
    S_R0, S_R1, S_R2, S_R3
  } state_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] outc_sel;
    logic [1:0] outd_sel;
    logic [2:0] fun_sel;
    logic [2:0] reg_sel;
    logic       arf_isel;
    logic       mem_rd;
    logic       mem_wr;
    logic       data_byte;
    logic       ir_load;
    logic       ir_lh;
    logic       pop_load;
  } ctl_t;

  // Register selects (active-low) and ARF function codes.
  localparam logic [2:0] RS_NONE = 3'b111;
  localparam logic [2:0] RS_PC   = 3'b011;
  localparam logic [2:0] RS_AR   = 3'b101;
  localparam logic [2:0] RS_SP   = 3'b110;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_WLO  = 3'b101;
  localparam logic [2:0] FS_WHI  = 3'b110;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b10;
  localparam logic [1:0] SEL_SP  = 2'b11;

  localparam ctl_t CTL_IDLE = '{
    busy: 1'b0, done: 1'b0, outc_sel: SEL_PC, outd_sel: SEL_PC,
    fun_sel: FS_DEC, reg_sel: RS_NONE, arf_isel: 1'b0, mem_rd: 1'b0,
    mem_wr: 1'b0, data_byte: 1'b0, ir_load: 1'b0, ir_lh: 1'b0, pop_load: 1'b0
  };

  state_t state;
  state_t nxt;
  ctl_t   ctl_q;

  // Moore decode of one micro-step; anything not named keeps its IDLE value.
  function automatic ctl_t decode(input state_t s);
    ctl_t c;
    c = CTL_IDLE;
    c.busy = (s != S_IDLE);
    case (s)
      // Instruction fetch: two bytes at PC, PC post-increments each byte.
      S_F0, S_F1: begin
        c.mem_rd  = 1'b1;
        c.ir_load = 1'b1;
        c.ir_lh   = (s == S_F1);
        c.reg_sel = RS_PC;
        c.fun_sel = FS_INC;
      end
      // Push AR: high byte first at SP, SP post-decrements each byte.
      S_P0, S_P1: begin
        c.outc_sel  = SEL_AR;
        c.outd_sel  = SEL_SP;
        c.mem_wr    = 1'b1;
        c.data_byte = (s == S_P0);
        c.reg_sel   = RS_SP;
        c.fun_sel   = FS_DEC;
      end
      // Pop: pre-increment SP, read low byte, increment again, read high byte.
      S_Q0: begin
        c.reg_sel = RS_SP;
        c.fun_sel = FS_INC;
      end
      S_Q1: begin
        c.outd_sel = SEL_SP;
        c.mem_rd   = 1'b1;
        c.pop_load = 1'b1;
        c.reg_sel  = RS_SP;
        c.fun_sel  = FS_INC;
      end
      S_Q2: begin
        c.outd_sel = SEL_SP;
        c.mem_rd   = 1'b1;
        c.pop_load = 1'b1;
        c.ir_lh    = 1'b1;
      end
      // Single-step loads from the external operand.
      S_LPC, S_LSP, S_LAR, S_C2: begin
        c.fun_sel = FS_LOAD;
        c.reg_sel = (s == S_LSP) ? RS_SP : ((s == S_LAR) ? RS_AR : RS_PC);
      end
      // Call: push PC (high byte first), then load PC with the target.
      S_C0, S_C1: begin
        c.outc_sel  = SEL_PC;
        c.outd_sel  = SEL_SP;
        c.mem_wr    = 1'b1;
        c.data_byte = (s == S_C0);
        c.reg_sel   = RS_SP;
        c.fun_sel   = FS_DEC;
      end
      // Return: mirror of the call push, writing PC a byte at a time from memory.
      S_R0, S_R2: begin
        c.reg_sel = RS_SP;
        c.fun_sel = FS_INC;
      end
      S_R1, S_R3: begin
        c.outd_sel = SEL_SP;
        c.mem_rd   = 1'b1;
        c.arf_isel = 1'b1;
        c.reg_sel  = RS_PC;
        c.fun_sel  = (s == S_R1) ? FS_WLO : FS_WHI;
      end
      default: ;
    endcase
    case (s)
      S_F1, S_P1, S_Q2, S_LPC, S_LSP, S_LAR, S_C2, S_R3: c.done = 1'b1;
      default: c.done = 1'b0;
    endcase
    return c;
  endfunction

  // Step sequencing; the op code is captured by which first step IDLE branches to.
  always_comb begin
    nxt = S_IDLE;
    case (state)
      S_IDLE: begin
        if (Start) begin
          case (Op)
            3'b000:  nxt = S_F0;
            3'b001:  nxt = S_P0;
            3'b010:  nxt = S_Q0;
            3'b011:  nxt = S_LPC;
            3'b100:  nxt = S_LSP;
            3'b101:  nxt = S_LAR;
            3'b110:  nxt = S_C0;
            default: nxt = S_R0;
          endcase
        end
      end
      S_F0:    nxt = S_F1;
      S_P0:    nxt = S_P1;
      S_Q0:    nxt = S_Q1;
      S_Q1:    nxt = S_Q2;
      S_C0:    nxt = S_C1;
      S_C1:    nxt = S_C2;
      S_R0:    nxt = S_R1;
      S_R1:    nxt = S_R2;
      S_R2:    nxt = S_R3;
      default: nxt = S_IDLE;
    endcase
  end

  // State and registered controls advance together so outputs always match the current step.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= S_IDLE;
      ctl_q <= CTL_IDLE;
    end else begin
      state <= nxt;
      ctl_q <= decode(nxt);
    end
  end

  assign Busy     = ctl_q.busy;
  assign Done     = ctl_q.done;
  assign OutCSel  = ctl_q.outc_sel;
  assign OutDSel  = ctl_q.outd_sel;
  assign FunSel   = ctl_q.fun_sel;
  assign RegSel   = ctl_q.reg_sel;
  assign ArfISel  = ctl_q.arf_isel;
  assign MemRd    = ctl_q.mem_rd;
  assign MemWr    = ctl_q.mem_wr;
  assign DataByte = ctl_q.data_byte;
  assign IRLoad   = ctl_q.ir_load;
  assign IRLH     = ctl_q.ir_lh;
  assign PopLoad  = ctl_q.pop_load;

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer: per-cycle control scoreboard plus a behavioural ARF/memory/IR datapath.
// Latency: expected step words are queued when Start is driven and popped every falling edge.
// Backpressure: bench respects the N+1 op spacing except where Start is deliberately held.
module tb_arf_sequencer;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [2:0] Op;
  logic       Busy, Done;
  logic [1:0] OutCSel, OutDSel;
  logic [2:0] FunSel, RegSel;
  logic       ArfISel, MemRd, MemWr, DataByte, IRLoad, IRLH, PopLoad;

  arf_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .Busy(Busy), .Done(Done), .OutCSel(OutCSel), .OutDSel(OutDSel),
    .FunSel(FunSel), .RegSel(RegSel), .ArfISel(ArfISel), .MemRd(MemRd),
    .MemWr(MemWr), .DataByte(DataByte), .IRLoad(IRLoad), .IRLH(IRLH),
    .PopLoad(PopLoad)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Word layout: Busy Done OutCSel OutDSel FunSel RegSel | ArfISel MemRd MemWr DataByte IRLoad IRLH PopLoad
  localparam logic [18:0] W_IDLE = {1'b0, 1'b0, 2'b00, 2'b00, 3'b000, 3'b111, 7'b0000000};
  logic [18:0] dut_w;
  assign dut_w = {Busy, Done, OutCSel, OutDSel, FunSel, RegSel,
                  ArfISel, MemRd, MemWr, DataByte, IRLoad, IRLH, PopLoad};

  int n_cmp = 0;
  int n_bad = 0;
  logic [18:0] sb[$];
  logic chk_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // flags = {ArfISel, MemRd, MemWr, DataByte, IRLoad, IRLH, PopLoad}
  function automatic logic [18:0] mk(input int d, input int cs, input int ds,
                                     input int fs, input int rs, input int f);
    logic [31:0] dv, csv, dsv, fsv, rsv, fv;
    dv = d; csv = cs; dsv = ds; fsv = fs; rsv = rs; fv = f;
    return {1'b1, dv[0], csv[1:0], dsv[1:0], fsv[2:0], rsv[2:0], fv[6:0]};
  endfunction

  function automatic int op_len(input logic [2:0] op);
    case (op)
      3'd0, 3'd1: return 2;
      3'd2, 3'd6: return 3;
      3'd7:       return 4;
      default:    return 1;
    endcase
  endfunction

  task automatic push_steps(input logic [2:0] op);
    case (op)
      3'd0: begin
        sb.push_back(mk(0, 0, 0, 'b001, 'b011, 'b0100100));
        sb.push_back(mk(1, 0, 0, 'b001, 'b011, 'b0100110));
      end
      3'd1: begin
        sb.push_back(mk(0, 2, 3, 'b000, 'b110, 'b0011000));
        sb.push_back(mk(1, 2, 3, 'b000, 'b110, 'b0010000));
      end
      3'd2: begin
        sb.push_back(mk(0, 0, 0, 'b001, 'b110, 'b0000000));
        sb.push_back(mk(0, 0, 3, 'b001, 'b110, 'b0100001));
        sb.push_back(mk(1, 0, 3, 'b000, 'b111, 'b0100011));
      end
      3'd3: sb.push_back(mk(1, 0, 0, 'b010, 'b011, 'b0000000));
      3'd4: sb.push_back(mk(1, 0, 0, 'b010, 'b110, 'b0000000));
      3'd5: sb.push_back(mk(1, 0, 0, 'b010, 'b101, 'b0000000));
      3'd6: begin
        sb.push_back(mk(0, 0, 3, 'b000, 'b110, 'b0011000));
        sb.push_back(mk(0, 0, 3, 'b000, 'b110, 'b0010000));
        sb.push_back(mk(1, 0, 0, 'b010, 'b011, 'b0000000));
      end
      default: begin
        sb.push_back(mk(0, 0, 0, 'b001, 'b110, 'b0000000));
        sb.push_back(mk(0, 0, 3, 'b101, 'b011, 'b1100000));
        sb.push_back(mk(0, 0, 0, 'b001, 'b110, 'b0000000));
        sb.push_back(mk(1, 0, 3, 'b110, 'b011, 'b1100000));
      end
    endcase
  endtask

  // Every falling edge: compare the full control word against the queue head (IDLE when empty).
  always @(negedge Clock) begin
    logic [18:0] e;
    if (chk_en) begin
      e = (sb.size() > 0) ? sb.pop_front() : W_IDLE;
      chk("ctl_word", 32'(dut_w), 32'(e));
    end
  end

  // Behavioural datapath driven by the DUT controls.
  logic [15:0] pc, ar, sp, ir, pop_val, ext_i;
  logic [7:0]  mem [0:65535];
  logic        preset = 1'b0;
  logic        p_wr;
  logic [15:0] p_pc, p_ar, p_sp, p_addr;
  logic [7:0]  p_lo, p_hi;

  function automatic logic [15:0] sel(input logic [1:0] s);
    case (s)
      2'b00:   return pc;
      2'b10:   return ar;
      2'b11:   return sp;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] arf_fn(input logic [15:0] r, input logic [2:0] fs, input logic [15:0] iv);
    case (fs)
      3'b000:  return r - 16'd1;
      3'b001:  return r + 16'd1;
      3'b010:  return iv;
      3'b101:  return {r[15:8], iv[7:0]};
      3'b110:  return {iv[7:0], r[7:0]};
      default: return r;
    endcase
  endfunction

  // Datapath update at each rising edge using the controls of the cycle just ending.
  always @(posedge Clock) begin
    logic [15:0] oc, od, iv;
    logic [7:0]  md;
    if (preset) begin
      pc <= p_pc; ar <= p_ar; sp <= p_sp;
      if (p_wr) begin
        mem[p_addr]         <= p_lo;
        mem[p_addr + 16'd1] <= p_hi;
      end
    end else begin
      oc = sel(OutCSel);
      od = sel(OutDSel);
      md = mem[od];
      iv = ArfISel ? {8'h00, md} : ext_i;
      if (MemWr) mem[od] <= DataByte ? oc[15:8] : oc[7:0];
      if (MemRd && IRLoad) begin
        if (IRLH) ir[15:8] <= md; else ir[7:0] <= md;
      end
      if (MemRd && PopLoad) begin
        if (IRLH) pop_val[15:8] <= md; else pop_val[7:0] <= md;
      end
      if (!RegSel[2]) pc <= arf_fn(pc, FunSel, iv);
      if (!RegSel[1]) ar <= arf_fn(ar, FunSel, iv);
      if (!RegSel[0]) sp <= arf_fn(sp, FunSel, iv);
    end
  end

  task automatic setup(input logic [15:0] a_pc, input logic [15:0] a_ar, input logic [15:0] a_sp,
                       input logic [15:0] a_ext, input logic wr, input logic [15:0] addr,
                       input logic [7:0] lo, input logic [7:0] hi);
    @(posedge Clock); #1;
    p_pc = a_pc; p_ar = a_ar; p_sp = a_sp; ext_i = a_ext;
    p_wr = wr; p_addr = addr; p_lo = lo; p_hi = hi;
    preset = 1'b1;
    @(posedge Clock); #1;
    preset = 1'b0;
  endtask

  // Drive one op in an IDLE cycle; returns during its last step, Op scrambled while busy.
  task automatic run_op(input logic [2:0] op);
    @(posedge Clock); #1;
    Start = 1'b1; Op = op;
    sb.push_back(W_IDLE);
    push_steps(op);
    @(posedge Clock); #1;
    Start = 1'b0; Op = 3'($urandom);
    repeat (op_len(op) - 1) @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    @(posedge Clock); #1;
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Op = 3'd0; ext_i = 16'h0000;
    p_wr = 1'b0; p_pc = '0; p_ar = '0; p_sp = '0; p_addr = '0; p_lo = '0; p_hi = '0;
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    chk_en = 1'b1;
    chk("rst_busy",   32'(Busy),   32'(1'b0));
    chk("rst_regsel", 32'(RegSel), 32'(3'b111));

    // Fetch two bytes at PC=0x0010.
    setup(16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h0010, 8'h34, 8'h12);
    run_op(3'd0);
    settle();
    chk("fetch_ir", 32'(ir), 32'(16'h1234));
    chk("fetch_pc", 32'(pc), 32'(16'h0012));

    // Push AR then pop it back.
    setup(16'h0000, 16'hBEEF, 16'h00FF, 16'h0000, 1'b0, 16'h0000, 8'h00, 8'h00);
    run_op(3'd1);
    settle();
    chk("push_hi", 32'(mem[16'h00FF]), 32'(8'hBE));
    chk("push_lo", 32'(mem[16'h00FE]), 32'(8'hEF));
    chk("push_sp", 32'(sp), 32'(16'h00FD));
    run_op(3'd2);
    settle();
    chk("pop_val", 32'(pop_val), 32'(16'hBEEF));
    chk("pop_sp",  32'(sp), 32'(16'h00FF));

    // Call then return.
    setup(16'h0123, 16'h0000, 16'h0080, 16'h0400, 1'b0, 16'h0000, 8'h00, 8'h00);
    run_op(3'd6);
    settle();
    chk("call_hi", 32'(mem[16'h0080]), 32'(8'h01));
    chk("call_lo", 32'(mem[16'h007F]), 32'(8'h23));
    chk("call_pc", 32'(pc), 32'(16'h0400));
    chk("call_sp", 32'(sp), 32'(16'h007E));
    run_op(3'd7);
    settle();
    chk("ret_pc", 32'(pc), 32'(16'h0123));
    chk("ret_sp", 32'(sp), 32'(16'h0080));

    // Single-step loads, each touching only its own register.
    for (int k = 3; k <= 5; k++) begin
      setup(16'h1111, 16'h2222, 16'h3333, 16'h5A5A, 1'b0, 16'h0000, 8'h00, 8'h00);
      run_op(3'(k));
      settle();
      chk("load_pc", 32'(pc), 32'((k == 3) ? 16'h5A5A : 16'h1111));
      chk("load_sp", 32'(sp), 32'((k == 4) ? 16'h5A5A : 16'h3333));
      chk("load_ar", 32'(ar), 32'((k == 5) ? 16'h5A5A : 16'h2222));
    end

    // Start held high through a RET: one RET, then LOADAR accepted in the IDLE cycle after Done.
    setup(16'h0000, 16'h0000, 16'h007E, 16'h1111, 1'b1, 16'h007F, 8'h78, 8'h56);
    @(posedge Clock); #1;
    Start = 1'b1; Op = 3'd7;
    sb.push_back(W_IDLE);
    push_steps(3'd7);
    sb.push_back(W_IDLE);
    push_steps(3'd5);
    @(posedge Clock); #1;
    Op = 3'd5;
    repeat (5) @(posedge Clock);
    #1;
    Start = 1'b0;
    settle();
    chk("hold_pc", 32'(pc), 32'(16'h5678));
    chk("hold_sp", 32'(sp), 32'(16'h0080));
    chk("hold_ar", 32'(ar), 32'(16'h1111));

    // Reset taken at the edge that would enter C1: only C0 commits.
    setup(16'h0200, 16'h0000, 16'h0040, 16'h0999, 1'b0, 16'h0000, 8'h00, 8'h00);
    @(posedge Clock); #1;
    Start = 1'b1; Op = 3'd6;
    sb.push_back(W_IDLE);
    sb.push_back(mk(0, 0, 3, 'b000, 'b110, 'b0011000));
    @(posedge Clock); #1;
    Start = 1'b0; Reset = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    chk("rst_mid_regsel", 32'(RegSel), 32'(3'b111));
    chk("rst_mid_memwr",  32'(MemWr),  32'(1'b0));
    chk("rst_mid_busy",   32'(Busy),   32'(1'b0));
    settle();
    chk("rst_mid_pc", 32'(pc), 32'(16'h0200));
    chk("rst_mid_sp", 32'(sp), 32'(16'h003F));
    chk("rst_mid_mem", 32'(mem[16'h0040]), 32'(8'h02));

    // Push with SP=0 wraps through 0xFFFF.
    setup(16'h0000, 16'hCAFE, 16'h0000, 16'h0000, 1'b0, 16'h0000, 8'h00, 8'h00);
    run_op(3'd1);
    settle();
    chk("wrap_hi", 32'(mem[16'h0000]), 32'(8'hCA));
    chk("wrap_lo", 32'(mem[16'hFFFF]), 32'(8'hFE));
    chk("wrap_sp", 32'(sp), 32'(16'hFFFE));

    repeat (3) @(posedge Clock);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
